pu_run_ctl: RTL

PU_RUN_CTL -- requirements
Module: pu_run_ctl

---
 rtl/pu_run_ctl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pu_run_ctl.sv
// Run/step/halt controller for a small processing unit: gates PC advance and
// register writes, handles breakpoints and counts retired instructions.
module pu_run_ctl #(
    parameter int PCW  = 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            step,
    input  logic            stop,
    input  logic            clr,
    input  logic            bp_en,
    input  logic [PCW-1:0]  bp_addr,
    input  logic [PCW-1:0]  pca,
    input  logic            h,
    input  logic            we_in,
    output logic            pc_en,
    output logic            we,
    output logic [1:0]      state,
    output logic            bp_hit,
    output logic            done,
    output logic [CNTW-1:0] cyc_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    state_t          state_q;
    logic            first_q;
    logic            bp_hit_q;
    logic            done_q;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic            bp_match;
    logic            retire;

    // The first RUN cycle after IDLE ignores the breakpoint so a resume
    // retires the instruction it stopped on.
    assign bp_match = bp_en && (pca == bp_addr) && !first_q;

    always_comb begin
        retire = 1'b0;
        case (state_q)
            RUN:     retire = !clr && !stop && !h && !bp_match;
            STEP:    retire = !clr && !stop && !h;
            default: retire = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (retire && (cnt_q != {CNTW{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // Reset gates the combinational enables immediately, without a clock edge.
    assign pc_en   = rst & retire;
    assign we      = rst & retire & we_in;
    assign state   = state_q;
    assign bp_hit  = bp_hit_q;
    assign done    = done_q;
    assign cyc_cnt = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            first_q  <= 1'b0;
            bp_hit_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            first_q <= 1'b0;
            cnt_q   <= cnt_d;
            if (clr) begin
                state_q  <= IDLE;
                bp_hit_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (stop) begin
                            state_q <= IDLE;
                        end else if (run) begin
                            state_q <= RUN;
                            first_q <= 1'b1;
                        end else if (step) begin
                            state_q <= STEP;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state_q <= IDLE;
                        end else if (h) begin
                            state_q <= HALT;
                            done_q  <= 1'b1;
                        end else if (bp_match) begin
                            state_q  <= IDLE;
                            bp_hit_q <= 1'b1;
                        end
                    end
                    STEP: begin
                        if (stop) begin
                            state_q <= IDLE;
                        end else if (h) begin
                            state_q <= HALT;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= HALT;
                endcase
            end
        end
    end

endmodule
